pc_branch_unit: RTL

- Registered program-counter unit for the processor core.
- Generalises the combinational PC + immediate jump adder into a clocked block with configurable address width and offset width.
- Supports conditional relative branch, absolute jump, and call/return through an internal return-address stack.
- Sits between the instruction decoder (supplies op, cond, offset, target) and instruction memory (consumes pc).

---
 rtl/pc_branch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// Registered program counter with relative branch, absolute jump and
// call/return through a small internal return-address stack.
module pc_branch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                OFF_W       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_BRC  = 3'd2;
  localparam logic [2:0] OP_JMP  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              taken_q, taken_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc, pc_rel, ret_addr;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic              full, empty;

  // Sign extension comes from sizing a signed offset up to the PC width;
  // both sums wrap silently at 2^ADDR_W.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign pc_rel   = pc_q + ADDR_W'($signed(offset));
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  // Only consumed when the stack is non-empty, so pop_idx is in range then.
  assign ret_addr = stack_q[pop_idx];

  // Next-state decode of the accepted op; reset is applied in the register.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    taken_d = 1'b0;
    fault_d = fault_q;
    stack_d = stack_q;
    if (en) begin
      case (op)
        OP_HOLD: ;
        OP_BRC: begin
          pc_d    = cond ? pc_rel : pc_inc;
          taken_d = cond;
        end
        OP_JMP: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_CALL: begin
          // Overflowing call still redirects; only the push is dropped.
          if (full) begin
            fault_d = 1'b1;
          end else begin
            stack_d[push_idx] = pc_inc;
            sp_d              = sp_q + SP_W'(1);
          end
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_RET: begin
          // Underflowing return falls through like INC and is not taken.
          if (empty) begin
            fault_d = 1'b1;
            pc_d    = pc_inc;
          end else begin
            sp_d    = sp_q - SP_W'(1);
            pc_d    = ret_addr;
            taken_d = 1'b1;
          end
        end
        default: pc_d = pc_inc;  // INC and reserved codes
      endcase
    end
  end

  // Control state with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      sp_q    <= '0;
      taken_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
    end
  end

  // Stack storage has no reset; a push is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) stack_q <= stack_d;
  end

  assign pc          = pc_q;
  assign taken       = taken_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign fault       = fault_q;

endmodule
